// File: rtl/adc_spi_scan_ctrl.sv
// Multi-channel scan controller for an LTC2308-class SPI SAR ADC.
// Drives CONVST/SCK/SDI, captures SDO and emits channel-tagged samples on a valid/ready stream.
module adc_spi_scan_ctrl #(
    parameter int unsigned DATA_BITS = 12,
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned T_CONVST  = 2,
    parameter int unsigned T_CONV    = 64,
    parameter int unsigned T_QUIET   = 5,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 cont_mode,
    input  logic                 uni_mode,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [CH_W-1:0]      out_ch,
    output logic                 overrun,
    output logic                 ADC_CONVST,
    output logic                 ADC_SCK,
    output logic                 ADC_SDI,
    input  logic                 ADC_SDO
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {StIdle, StCnvst, StConv, StShift, StQuiet} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [NUM_CH-1:0]      mask_q;
    logic                   cont_q;
    logic                   uni_q;
    logic [CH_W-1:0]        cfg_ch;
    logic [CH_W-1:0]        data_ch;
    logic                   priming;
    logic                   last_q;
    logic                   sampled_q;
    logic                   stop_q;
    logic [5:0]             cfg_sr;
    logic [DATA_BITS-1:0]   data_sr;

    function automatic logic [CH_W-1:0] first_set(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // Lowest set bit above cur, wrapping to the lowest set bit overall.
    function automatic logic [CH_W-1:0] next_set(input logic [NUM_CH-1:0] m,
                                                 input logic [CH_W-1:0]   cur);
        logic [CH_W-1:0] r;
        r = first_set(m);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && i > int'(cur)) r = CH_W'(i);
        end
        return r;
    endfunction

    logic [CH_W-1:0] first_ch;
    logic [CH_W-1:0] next_ch;
    logic [2:0]      ch3;
    logic [5:0]      cfg_word;
    logic            finish;

    always_comb begin
        first_ch = first_set(mask_q);
        next_ch  = next_set(mask_q, cfg_ch);
        ch3      = 3'(cfg_ch);
        cfg_word = {1'b1, ch3[0], ch3[2], ch3[1], uni_q, 1'b0};
        finish   = cont_q ? ((stop_q || stop) && sampled_q) : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            cnt        <= '0;
            bit_cnt    <= '0;
            mask_q     <= '0;
            cont_q     <= 1'b0;
            uni_q      <= 1'b0;
            cfg_ch     <= '0;
            data_ch    <= '0;
            priming    <= 1'b0;
            last_q     <= 1'b0;
            sampled_q  <= 1'b0;
            stop_q     <= 1'b0;
            cfg_sr     <= '0;
            data_sr    <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            overrun    <= 1'b0;
            ADC_CONVST <= 1'b0;
            ADC_SCK    <= 1'b0;
            ADC_SDI    <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (stop && state != StIdle) stop_q <= 1'b1;

            case (state)
                StIdle: begin
                    if (start && |ch_mask) begin
                        state      <= StCnvst;
                        ADC_CONVST <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        mask_q     <= ch_mask;
                        cont_q     <= cont_mode;
                        uni_q      <= uni_mode;
                        cfg_ch     <= first_set(ch_mask);
                        priming    <= 1'b1;
                        stop_q     <= 1'b0;
                        overrun    <= 1'b0;
                    end
                end
                StCnvst: begin
                    if (cnt == CNT_W'(T_CONVST - 1)) begin
                        state      <= StConv;
                        ADC_CONVST <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StConv: begin
                    if (cnt == CNT_W'(T_CONV - 1)) begin
                        state   <= StShift;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        ADC_SDI <= cfg_word[5];
                        cfg_sr  <= {cfg_word[4:0], 1'b0};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StShift: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt <= '0;
                        if (!ADC_SCK) begin
                            ADC_SCK <= 1'b1;
                            data_sr <= {data_sr[DATA_BITS-2:0], ADC_SDO};
                        end else begin
                            ADC_SCK <= 1'b0;
                            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                                state     <= StQuiet;
                                ADC_SDI   <= 1'b0;
                                sampled_q <= !priming;
                                // Priming frame data belongs to no channel of this scan.
                                if (!priming) begin
                                    out_valid <= 1'b1;
                                    out_data  <= data_sr;
                                    out_ch    <= data_ch;
                                    if (out_valid && !out_ready) overrun <= 1'b1;
                                end
                                last_q  <= !cont_q && !priming && (cfg_ch == first_ch);
                                data_ch <= cfg_ch;
                                cfg_ch  <= next_ch;
                                priming <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                ADC_SDI <= cfg_sr[5];
                                cfg_sr  <= {cfg_sr[4:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StQuiet: begin
                    if (cnt == CNT_W'(T_QUIET - 1)) begin
                        cnt <= '0;
                        if (finish) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            state      <= StCnvst;
                            ADC_CONVST <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
